// File: rtl/led_cmd_ctrl.sv
// Serial LED command controller: decodes {mode, addr} frames shifted in on SCK and committed on LATCH.
// Optional build macro LED_CTRL_BROADCAST_EN: address 2^ADDR_W-1 writes the mode to every LED.
//
// state   | meaning
// S_IDLE  | no bits shifted since the last commit or reset
// S_SHIFT | 1..FRAME_W-1 bits shifted
// S_FULL  | exactly FRAME_W bits shifted, frame ready to commit
// S_OVER  | more than FRAME_W bits seen, further SCK edges ignored
module led_cmd_ctrl #(
    parameter int N_LEDS    = 16,
    parameter int ADDR_W    = 5,
    parameter int BLINK_DIV = 1024
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCK,
    input  logic              DATA,
    input  logic              LATCH,
    input  logic              PATTERN,
    output logic [N_LEDS-1:0] LED,
    output logic              CMD_VALID,
    output logic              FRAME_ERR
);

    localparam int FRAME_W = ADDR_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int PRE_W   = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FULL,
        S_OVER
    } state_t;

    logic [1:0] sck_sync, data_sync, latch_sync, pat_sync;
    logic       sck_prev, latch_prev;
    logic       sck_rise, latch_rise;

    state_t                     state_q, state_n;
    logic [CNT_W-1:0]           cnt_q, cnt_n;
    logic [FRAME_W-1:0]         sreg_q, sreg_n;
    logic [N_LEDS-1:0][1:0]     mode_q, mode_n;
    logic                       cmd_valid_n, frame_err_n;
    logic [1:0]                 frm_mode;
    logic [ADDR_W-1:0]          frm_addr;
    logic                       hit;

    logic [PRE_W-1:0]           pre_q;
    logic                       blink_q;
    logic [N_LEDS-1:0]          led_n;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sck_sync   <= '0;
            data_sync  <= '0;
            latch_sync <= '0;
            pat_sync   <= '0;
            sck_prev   <= 1'b0;
            latch_prev <= 1'b0;
        end else begin
            sck_sync   <= {sck_sync[0], SCK};
            data_sync  <= {data_sync[0], DATA};
            latch_sync <= {latch_sync[0], LATCH};
            pat_sync   <= {pat_sync[0], PATTERN};
            sck_prev   <= sck_sync[1];
            latch_prev <= latch_sync[1];
        end
    end

    assign sck_rise   = sck_sync[1] & ~sck_prev;
    assign latch_rise = latch_sync[1] & ~latch_prev;
    assign frm_mode   = sreg_q[FRAME_W-1 -: 2];
    assign frm_addr   = sreg_q[ADDR_W-1:0];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sreg_q    <= '0;
            mode_q    <= '0;
            CMD_VALID <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            sreg_q    <= sreg_n;
            mode_q    <= mode_n;
            CMD_VALID <= cmd_valid_n;
            FRAME_ERR <= frame_err_n;
        end
    end

    // A LATCH edge takes priority; an SCK edge in the same cycle is dropped.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        sreg_n      = sreg_q;
        mode_n      = mode_q;
        cmd_valid_n = 1'b0;
        frame_err_n = 1'b0;
        hit         = 1'b0;
        if (latch_rise) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            case (state_q)
                S_FULL: begin
                    for (int i = 0; i < N_LEDS; i++) begin
                        if (int'(frm_addr) == i) begin
                            mode_n[i] = frm_mode;
                            hit       = 1'b1;
                        end
                    end
`ifdef LED_CTRL_BROADCAST_EN
                    if (frm_addr == {ADDR_W{1'b1}}) begin
                        for (int i = 0; i < N_LEDS; i++) begin
                            mode_n[i] = frm_mode;
                        end
                        hit = 1'b1;
                    end
`else
`endif
                    cmd_valid_n = hit;
                end
                S_SHIFT, S_OVER: frame_err_n = 1'b1;
                default: ;
            endcase
        end else if (sck_rise) begin
            case (state_q)
                S_IDLE: begin
                    sreg_n  = {sreg_q[FRAME_W-2:0], data_sync[1]};
                    cnt_n   = CNT_W'(1);
                    state_n = S_SHIFT;
                end
                S_SHIFT: begin
                    sreg_n = {sreg_q[FRAME_W-2:0], data_sync[1]};
                    cnt_n  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_n = S_FULL;
                end
                S_FULL: begin
                    sreg_n  = {sreg_q[FRAME_W-2:0], data_sync[1]};
                    state_n = S_OVER;
                end
                default: ;
            endcase
        end
    end

    // Free-running prescaler; commands never restart it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pre_q   <= '0;
            blink_q <= 1'b0;
        end else if (pre_q == PRE_LAST) begin
            pre_q   <= '0;
            blink_q <= ~blink_q;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    always_comb begin
        led_n = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            case (mode_q[i])
                2'b00:   led_n[i] = 1'b0;
                2'b01:   led_n[i] = 1'b1;
                2'b10:   led_n[i] = pat_sync[1];
                default: led_n[i] = blink_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) LED <= '0;
        else        LED <= led_n;
    end

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Randomized scoreboard bench for led_cmd_ctrl: expected commit/error events are queued at LATCH time
// and a negedge monitor checks pulses and the full LED vector against a per-LED mode model.
module tb_led_cmd_ctrl;

    localparam int N_LEDS    = 16;
    localparam int ADDR_W    = 5;
    localparam int BLINK_DIV = 4;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              SCK = 1'b0;
    logic              DATA = 1'b0;
    logic              LATCH = 1'b0;
    logic              PATTERN = 1'b0;
    logic [N_LEDS-1:0] LED;
    logic              CMD_VALID;
    logic              FRAME_ERR;

    led_cmd_ctrl #(
        .N_LEDS   (N_LEDS),
        .ADDR_W   (ADDR_W),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .SCK      (SCK),
        .DATA     (DATA),
        .LATCH    (LATCH),
        .PATTERN  (PATTERN),
        .LED      (LED),
        .CMD_VALID(CMD_VALID),
        .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         is_err;
        logic [1:0] mode;
        int         addr;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fails  = 0;
    logic [1:0] model_mode [N_LEDS];
    int         cyc;
    bit   [3:0] pat_hist = '0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fails++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, actual, required, $time);
        end
    endtask

    // Edges since reset release, counted the same way the pad-level host would see them.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge CLK) begin : monitor
        logic [N_LEDS-1:0] exp_led;
        exp_t              e;
        pat_hist = {pat_hist[2:0], PATTERN};
        if (!RESET) begin
            check("reset_led", 32'(LED), 32'd0);
            check("reset_cmd_valid", 32'(CMD_VALID), 32'd0);
            check("reset_frame_err", 32'(FRAME_ERR), 32'd0);
            for (int i = 0; i < N_LEDS; i++) model_mode[i] = 2'b00;
        end else begin
            for (int i = 0; i < N_LEDS; i++) begin
                case (model_mode[i])
                    2'b00:   exp_led[i] = 1'b0;
                    2'b01:   exp_led[i] = 1'b1;
                    2'b10:   exp_led[i] = pat_hist[3];
                    default: exp_led[i] = (((cyc - 1) / BLINK_DIV) % 2) == 1;
                endcase
            end
            check("led", 32'(LED), 32'(exp_led));
            if (CMD_VALID || FRAME_ERR) begin
                if (CMD_VALID && FRAME_ERR) begin
                    check("pulse_exclusive", 32'(FRAME_ERR), 32'(!CMD_VALID));
                end else if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_pulse: actual cmd_valid=%0b frame_err=%0b required no pulse at %0t",
                             CMD_VALID, FRAME_ERR, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_err", 32'(FRAME_ERR), 32'(e.is_err));
                    if (!e.is_err) begin
                        if (e.addr >= N_LEDS) begin
                            for (int i = 0; i < N_LEDS; i++) model_mode[i] = e.mode;
                        end else begin
                            model_mode[e.addr] = e.mode;
                        end
                    end
                end
            end
        end
    end

    // PATTERN is randomized every cycle so pattern-mode LEDs are exercised continuously.
    initial begin
        forever begin
            @(posedge CLK);
            #1 PATTERN = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual time %0t required completion earlier", $time);
        n_fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_bits(input int nbits, input logic [6:0] frame);
        for (int i = 0; i < nbits; i++) begin
            DATA = (i < 7) ? frame[6 - i] : 1'($urandom_range(0, 1));
            tick(4);
            SCK = 1'b1;
            tick(4);
            SCK = 1'b0;
        end
    endtask

    task automatic predict(input int nbits, input logic [6:0] frame);
        exp_t e;
        int   addr;
        addr   = int'(frame[4:0]);
        e.mode = frame[6:5];
        e.addr = addr;
        if (nbits == 0) begin
        end else if (nbits != 7) begin
            e.is_err = 1'b1;
            exp_q.push_back(e);
        end else if (addr < N_LEDS) begin
            e.is_err = 1'b0;
            exp_q.push_back(e);
        end else begin
`ifdef LED_CTRL_BROADCAST_EN
            if (addr == (1 << ADDR_W) - 1) begin
                e.is_err = 1'b0;
                exp_q.push_back(e);
            end
`endif
        end
    endtask

    task automatic send_frame(input int nbits, input logic [6:0] frame, input bit simul);
        send_bits(nbits, frame);
        predict(nbits, frame);
        tick(4);
        if (simul) begin
            DATA  = 1'($urandom_range(0, 1));
            SCK   = 1'b1;
            LATCH = 1'b1;
            tick(4);
            SCK   = 1'b0;
            LATCH = 1'b0;
        end else begin
            LATCH = 1'b1;
            tick(4);
            LATCH = 1'b0;
        end
        tick(4);
    endtask

    int nb_tab[10] = '{0, 3, 5, 6, 7, 7, 7, 7, 8, 9};

    initial begin
        RESET = 1'b0;
        tick(5);
        RESET = 1'b1;
        tick(4);

        send_frame(7, 7'h23, 1'b0);
        tick(4);
        send_frame(7, 7'h45, 1'b0);
        tick(30);
        send_frame(7, 7'h6F, 1'b0);
        tick(20);
        send_frame(5, 7'h11, 1'b0);
        send_frame(8, 7'h12, 1'b0);
        send_frame(7, 7'h3F, 1'b0);
        tick(8);
        send_frame(0, 7'h00, 1'b0);

        send_bits(4, 7'h5A);
        RESET = 1'b0;
        tick(3);
        RESET = 1'b1;
        tick(4);
        send_frame(7, 7'h23, 1'b0);
        tick(6);

        send_frame(7, 7'h27, 1'b1);
        send_frame(6, 7'h48, 1'b1);
        send_frame(7, 7'h7A, 1'b0);

        for (int k = 0; k < 40; k++) begin
            send_frame(nb_tab[$urandom_range(0, 9)], 7'($urandom), ($urandom_range(0, 3) == 0));
            tick($urandom_range(0, 6));
        end

        tick(20);
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/led_cmd_ctrl.md
# led_cmd_ctrl

Parametrised, fully synchronous serial LED command controller. It sits between the host MCU's bit-banged serial link (CLK-domain-asynchronous SCK/DATA/LATCH) and the board's LED drivers. It decodes fixed-length frames into per-LED modes (off, on, follow PATTERN, internal blink) and drives registered LED outputs. It also flags malformed frames.

## Interface
Parameters:
- N_LEDS, 16, number of LED outputs (1..2^ADDR_W-1)
- ADDR_W, 5, address field width; frame width FRAME_W = ADDR_W+2
- BLINK_DIV, 1024, CLK cycles per blink half-period (>=2)

Ports:
- CLK  in  1  system clock; all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- SCK  in  1  serial bit clock from host, asynchronous to CLK
- DATA  in  1  serial data, sampled on SCK rising edge
- LATCH  in  1  frame commit strobe, rising edge commits
- PATTERN  in  1  external pattern signal, asynchronous
- LED  out  N_LEDS  registered LED drive
- CMD_VALID  out  1  one-cycle pulse: frame accepted and applied
- FRAME_ERR  out  1  one-cycle pulse: frame discarded (wrong bit count)

## Operation
- SCK, DATA, LATCH and PATTERN each pass through a 2-flop synchronizer. SCK and LATCH then feed a rising-edge detector (previous-value flop).
- Frame = {mode[1:0], addr[ADDR_W-1:0]}, MSB first. The first bit shifted is mode[1].
- Mode encoding: 00 off, 01 on, 10 LED = synced PATTERN, 11 LED = blink phase.
- Frame FSM states:
  - IDLE (bit count 0)
  - SHIFT (1..FRAME_W-1 bits)
  - FULL (exactly FRAME_W bits)
  - OVER (more than FRAME_W bits; further SCK edges are ignored)
- Each SCK edge shifts the synced DATA into the shift register and increments the count, saturating at OVER.
- On a LATCH edge:
  - FULL: decode and apply the frame; CMD_VALID pulses.
  - SHIFT or OVER: discard the frame; FRAME_ERR pulses.
  - IDLE: no action, no pulse.
  - All cases return the FSM to IDLE and clear the count.
- Apply rules:
  - addr < N_LEDS: mode[addr] <= mode field.
  - Any other addr: no update and no pulse on either output, except the broadcast case (see Configuration).
- Simultaneous SCK and LATCH edges in the same cycle: LATCH wins. The frame is evaluated on the count before the edge, and the SCK bit is dropped.
- Blink: a prescaler counts 0..BLINK_DIV-1 and wraps to 0. The blink phase toggles on each wrap. The prescaler is free-running and is not restarted by commands.
- Reset (asserted at any time, including mid-frame): clears the shift register, count, FSM (IDLE), all modes (00), prescaler, blink phase (0), synchronizers and edge flops. LED = 0, CMD_VALID = 0, FRAME_ERR = 0.

## Timing
- Pad-to-edge-detect latency: 3 CLK cycles; 2 synchronizer cycles, then the edge is seen in the 3rd.
- Let L be the cycle in which a LATCH edge is detected:
  - Mode register updated at the end of L.
  - CMD_VALID or FRAME_ERR high during L+1 only.
  - LED reflects the new mode at L+2.
- In PATTERN mode, LED follows the PATTERN pad with 3 cycles of latency (2 sync flops + output register).
- Blink: LED toggles every BLINK_DIV cycles; full period 2*BLINK_DIV.
- Host requirements:
  - SCK high and low phases each ≥ 3 CLK cycles.
  - DATA stable ≥ 3 CLK cycles around the SCK rising edge.
  - LATCH high and low phases each ≥ 3 CLK cycles.

## Configuration
- Macro LED_CTRL_BROADCAST_EN.
- Defined: addr = 2^ADDR_W-1 writes the mode field to all N_LEDS entries in the same cycle, and CMD_VALID pulses. Requires N_LEDS < 2^ADDR_W.
- Undefined: that address is handled as an ordinary out-of-range address (no update, no pulse).

## Test plan
- Reset release, then shift 0x23 (7 bits) and LATCH → CMD_VALID pulse at L+1; LED = 16'h0008 at L+2; FRAME_ERR stays 0.
- Shift 0x45, LATCH, then toggle PATTERN 0→1→0 → LED[5] tracks PATTERN with 3-cycle latency; all other LEDs unchanged.
- BLINK_DIV = 4, shift 0x6F, LATCH → LED[15] toggles every 4 cycles, in phase with the free-running prescaler.
- Shift 5 bits, LATCH → FRAME_ERR pulse, no CMD_VALID, LED unchanged. Repeat with 8 bits → same result.
- With LED_CTRL_BROADCAST_EN, shift 0x3F and LATCH → LED = 16'hFFFF and one CMD_VALID pulse. Without the macro → LED unchanged and no pulses.
- Assert RESET after 4 bits of a frame, release, then send a full 0x23 frame → LED = 16'h0008 with CMD_VALID and no FRAME_ERR (the partial bits were discarded).
